// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit.
//
// Takes one operand bit per cycle. Multiplication is shift-add over a
// 2*XLEN accumulator. Division is restoring division. Both run on operand
// magnitudes, and the sign is fixed up on the completing edge. Divide by
// zero and signed overflow complete on the accept edge.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_valid / o_ready   request handshake; o_ready is high only when idle
//   i_op                RV funct3 (MUL..REMU)
//   i_rs1 / i_rs2       operand A (multiplicand/dividend), B (multiplier/divisor)
//   i_rd_addr           destination tag, returned on o_rd_addr
//   i_flush             drops any in-flight or pending result
//   o_valid / i_ready   result handshake; o_rd_wen mirrors o_valid
//   o_result            registered result, held until consumed
//   o_busy              unit is not idle
module exu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_wen,
  output logic            o_busy
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OpMulh  = 3'b001;
  localparam logic [2:0] OpMulhu = 3'b011;
  localparam logic [2:0] OpDiv   = 3'b100;
  localparam logic [2:0] OpDivu  = 3'b101;
  localparam logic [2:0] OpRem   = 3'b110;
  localparam logic [2:0] OpRemu  = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   a_q;        // |A|, multiplicand
  logic [XLEN-1:0]   b_q;        // |B|, divisor
  logic              neg_res_q;  // product/quotient needs negation
  logic              neg_a_q;    // remainder takes the sign of A
  logic [2*XLEN-1:0] prod_q;     // high: partial sum, low: multiplier being shifted out
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;      // dividend bits shift out as quotient bits shift in
  logic [XLEN-1:0]   result_q;

  // Accept-time decode
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_signed = (i_op != OpMulhu) && (i_op != OpDivu) && (i_op != OpRemu);
    b_signed = (i_op == OpMulh) || (i_op == OpDiv) || (i_op == OpRem);
    a_neg    = a_signed & i_rs1[XLEN-1];
    b_neg    = b_signed & i_rs2[XLEN-1];
    a_mag    = a_neg ? -i_rs1 : i_rs1;
    b_mag    = b_neg ? -i_rs2 : i_rs2;
    div_zero = i_op[2] && (i_rs2 == '0);
    div_ovf  = i_op[2] && !i_op[0] && (i_rs1 == MinNeg) && (i_rs2 == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) begin
      fast_res = i_op[1] ? i_rs1 : '1;
    end else begin
      fast_res = i_op[1] ? '0 : i_rs1;
    end
  end

  // One iteration of each datapath, plus the sign fix-up applied on the last one
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN+1:0]   rem_wide, rem_trial;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quo_step;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    rem_wide  = {rem_q, quo_q[XLEN-1]};
    rem_trial = rem_wide - {2'b00, b_q};
    // Top bit set means the trial subtract went negative: restore
    rem_step  = rem_trial[XLEN+1] ? rem_wide[XLEN:0] : rem_trial[XLEN:0];
    quo_step  = {quo_q[XLEN-2:0], ~rem_trial[XLEN+1]};
    prod_fix  = neg_res_q ? -prod_step : prod_step;
    if (op_q[2]) begin
      if (op_q[1]) begin
        calc_res = neg_a_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
      end else begin
        calc_res = neg_res_q ? -quo_step : quo_step;
      end
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
    end else if (i_flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            op_q      <= i_op;
            rd_q      <= i_rd_addr;
            cnt_q     <= '0;
            a_q       <= a_mag;
            b_q       <= b_mag;
            neg_res_q <= a_neg ^ b_neg;
            neg_a_q   <= a_neg;
            prod_q    <= {{XLEN{1'b0}}, b_mag};
            rem_q     <= '0;
            quo_q     <= a_mag;
            if (fast) begin
              result_q <= fast_res;
              state_q  <= StDone;
            end else begin
              state_q  <= StCalc;
            end
          end
        end
        StCalc: begin
          prod_q <= prod_step;
          rem_q  <= rem_step;
          quo_q  <= quo_step;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            result_q <= calc_res;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_busy    = (state_q != StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_rd_wen  = o_valid;
  assign o_result  = result_q;
  assign o_rd_addr = rd_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed testbench for exu_muldiv (XLEN = 32).
module tb_exu_muldiv;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [4:0]      i_rd_addr;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wen;
  logic            o_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  exu_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_rd_addr (i_rd_addr),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_rd_addr (o_rd_addr),
    .o_rd_wen  (o_rd_wen),
    .o_busy    (o_busy)
  );

  // Present a request for one cycle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd_addr = rd;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Latency in cycles counted from the request cycle; capped at 100.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_rd_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b wen=%b required 0 1 0 0",
               o_valid, o_ready, o_busy, o_rd_wen);
    end
    checks++;
    if (o_result !== 32'h0 || o_rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: got result=%h rd=%0d required 0 0", o_result, o_rd_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_mul();
    vec_t v[4];
    int   lat;
    v[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    v[1] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
    v[2] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000};
    v[3] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      wait_valid(lat);
      checks++;
      if (lat !== 33) begin
        errors++; $display("FAIL mul[%0d]_latency: got %0d required 33", i, lat);
      end
      checks++;
      if (o_result !== v[i].exp) begin
        errors++; $display("FAIL mul[%0d]_result: got %h required %h", i, o_result, v[i].exp);
      end
      checks++;
      if (o_rd_addr !== v[i].rd || o_rd_wen !== 1'b1) begin
        errors++;
        $display("FAIL mul[%0d]_tag: got rd=%0d wen=%b required rd=%0d wen=1",
                 i, o_rd_addr, o_rd_wen, v[i].rd);
      end
      consume();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL mul[%0d]_release: got valid=%b ready=%b required 0 1", i, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[4];
    int   lat;
    v[0] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD};
    v[1] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF};
    v[2] = '{3'b101, 32'd100,       32'd7,         5'd12, 32'd14};
    v[3] = '{3'b111, 32'd100,       32'd7,         5'd13, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      wait_valid(lat);
      checks++;
      if (lat !== 33) begin
        errors++; $display("FAIL div[%0d]_latency: got %0d required 33", i, lat);
      end
      checks++;
      if (o_result !== v[i].exp) begin
        errors++; $display("FAIL div[%0d]_result: got %h required %h", i, o_result, v[i].exp);
      end
      checks++;
      if (o_rd_addr !== v[i].rd) begin
        errors++; $display("FAIL div[%0d]_tag: got %0d required %0d", i, o_rd_addr, v[i].rd);
      end
      consume();
    end
  endtask

  task automatic test_fast_path();
    vec_t v[4];
    int   lat;
    v[0] = '{3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF};
    v[1] = '{3'b110, 32'd5,         32'd0,         5'd15, 32'd5};
    v[2] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000};
    v[3] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      wait_valid(lat);
      checks++;
      if (lat !== 1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL fast[%0d]_latency: got lat=%0d busy=%b required lat=1 busy=1",
                 i, lat, o_busy);
      end
      checks++;
      if (o_result !== v[i].exp || o_rd_addr !== v[i].rd) begin
        errors++;
        $display("FAIL fast[%0d]_result: got %h rd=%0d required %h rd=%0d",
                 i, o_result, o_rd_addr, v[i].exp, v[i].rd);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
    wait_valid(lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL bp_latency: got %0d required 33", lat);
    end
    // Second request held high during the stall must not be taken
    i_valid = 1'b1; i_op = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd_addr = 5'd9;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'hFFFF_FFFE ||
          o_rd_addr !== 5'd20) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_consume: got valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: got ready=%b busy=%b required 0 1", o_ready, o_busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 33 || o_result !== 32'd14 || o_rd_addr !== 5'd9) begin
      errors++;
      $display("FAIL bp_next_result: got lat=%0d result=%h rd=%0d required 33 0000000e 9",
               lat, o_result, o_rd_addr);
    end
    consume();
  endtask

  task automatic test_flush();
    int seen;
    issue(3'b000, 32'd3, 32'd4, 5'd1);
    repeat (15) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: got ready=%b busy=%b valid=%b required 1 0 0",
               o_ready, o_busy, o_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_result: got %0d valid cycles required 0", seen);
    end
    issue(3'b101, 32'd5, 32'd0, 5'd3);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL flush_done_setup: got valid=%b required 1", o_valid);
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: got valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
    // Flush wins over a simultaneous request
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'b000; i_rs1 = 32'd2; i_rs2 = 32'd2;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_accept: got ready=%b busy=%b required 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(3'b000, 32'd5, 32'd5, 5'd6);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got busy=%b ready=%b valid=%b required 0 1 0",
               o_busy, o_ready, o_valid);
    end
    checks++;
    if (o_result !== 32'h0 || o_rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_data: got result=%h rd=%0d required 0 0", o_result, o_rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'b000, 32'd3, 32'd4, 5'd7);
    wait_valid(lat);
    checks++;
    if (lat !== 33 || o_result !== 32'd12 || o_rd_addr !== 5'd7) begin
      errors++;
      $display("FAIL rst_mid_after: got lat=%0d result=%h rd=%0d required 33 0000000c 7",
               lat, o_result, o_rd_addr);
    end
    consume();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0; i_rd_addr = '0;
    i_flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
